// File: rtl/gen_arbiter.sv
// ============================================================================
// gen_arbiter : N-way arbiter with registered, held grants. Policy is picked
// by MODE (0/other = fixed priority, 1 = round-robin). Define
// ARB_HOLD_LIMIT_EN to build the MAX_HOLD ownership limit.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module gen_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_idx,
  output logic                     expired
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             take_new;
  logic             release_now;
  logic             expire_now;
  logic             owner_req;
  logic [N_REQ-1:0] cand;
  logic [IW-1:0]    win_idx;
  logic             win_valid;

  if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 1) begin : g_param_check
    $error("gen_arbiter: illegal parameterisation");
  end

  assign owner_req   = req[gnt_idx];
  assign release_now = (state_q == OWNED) && (!owner_req || expire_now);
  // An expiring owner sits out exactly one arbitration.
  assign cand        = expire_now ? (req & ~gnt) : req;

  // --------------------------------------------------------------------------
  // Policy selection
  // --------------------------------------------------------------------------
  case (MODE)
    0: begin : g_fixed
      always_comb begin
        win_valid = |cand;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
          if (cand[i]) win_idx = IW'(i);
        end
      end
    end

    1: begin : g_rr
      logic [IW-1:0] rr_ptr;
      logic [IW:0]   slot;

      always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        slot      = '0;
        for (int k = 0; k < N_REQ; k++) begin
          slot = {1'b0, rr_ptr} + (IW + 1)'(k);
          if (slot >= (IW + 1)'(N_REQ)) slot = slot - (IW + 1)'(N_REQ);
          if (!win_valid && cand[slot[IW-1:0]]) begin
            win_valid = 1'b1;
            win_idx   = slot[IW-1:0];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rr_ptr <= '0;
        end else if (take_new) begin
          rr_ptr <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
      end
    end

    default: begin : g_fixed_dflt
      always_comb begin
        win_valid = |cand;
        win_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
          if (cand[i]) win_idx = IW'(i);
        end
      end
    end
  endcase

  // --------------------------------------------------------------------------
  // Ownership FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    take_new = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          take_new = 1'b1;
          state_d  = OWNED;
        end
      end
      OWNED: begin
        if (release_now) begin
          if (win_valid) take_new = 1'b1;
          else           state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
    end else begin
      state_q <= state_d;
      if (take_new) begin
        gnt       <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
        gnt_valid <= 1'b1;
        gnt_idx   <= win_idx;
      end else if (state_d == IDLE) begin
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_idx   <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hold limit
  // --------------------------------------------------------------------------
`ifdef ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt;

  assign expire_now = (state_q == OWNED) && (hold_cnt == CW'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      expired  <= 1'b0;
    end else begin
      expired <= expire_now;
      if (take_new) begin
        hold_cnt <= CW'(1);
      end else if (state_d == IDLE) begin
        hold_cnt <= '0;
      end else if (hold_cnt != CW'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign expire_now = 1'b0;
  assign expired    = 1'b0;
`endif

endmodule

`default_nettype wire
